// File: rtl/regfile_wr_arbiter_if.sv
// Write-port arbitration bus: two writeback requesters on one side, the
// register-file write port and pending-write mask on the other.
// slave  : the arbiter
// master : the requesters / register file environment
interface regfile_wr_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 2
);
    // requester 0
    logic                   Req0;
    logic [REG_AW-1:0]      WrRegNo0;
    logic [DATA_W-1:0]      WrData0;
    logic                   Ready0;
    // requester 1
    logic                   Req1;
    logic [REG_AW-1:0]      WrRegNo1;
    logic [DATA_W-1:0]      WrData1;
    logic                   Ready1;
    // register-file write port
    logic                   RegWrite;
    logic [REG_AW-1:0]      WriteRegNo;
    logic [DATA_W-1:0]      WriteData;
    logic                   GrantId;
    // pending-write mask for hazard checks
    logic [2**REG_AW-1:0]   Busy;

    modport master (
        output Req0, WrRegNo0, WrData0,
        output Req1, WrRegNo1, WrData1,
        input  Ready0, Ready1,
        input  RegWrite, WriteRegNo, WriteData, GrantId, Busy
    );

    modport slave (
        input  Req0, WrRegNo0, WrData0,
        input  Req1, WrRegNo1, WrData1,
        output Ready0, Ready1,
        output RegWrite, WriteRegNo, WriteData, GrantId, Busy
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter.
// Two one-entry holding registers (valid/ready in) are drained round-robin
// into a registered write stage (RegWrite/WriteRegNo/WriteData/GrantId).
// Busy flags every register with a write held or on the write port.
// Build option ARB_FIXED_PRIO_EN: requester 0 always wins a tie and the
// round-robin pointer is removed (requester 1 may starve).
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    regfile_wr_arbiter_if.slave bus
);
    localparam int NREG = 2**REG_AW;

    // requester inputs gathered into indexable form
    logic [1:0]         req;
    logic [REG_AW-1:0]  req_reg  [2];
    logic [DATA_W-1:0]  req_data [2];

    assign req         = {bus.Req1, bus.Req0};
    assign req_reg[0]  = bus.WrRegNo0;
    assign req_reg[1]  = bus.WrRegNo1;
    assign req_data[0] = bus.WrData0;
    assign req_data[1] = bus.WrData1;

    // holding-register state seen by the arbiter
    logic [1:0]         full_v;
    logic [REG_AW-1:0]  hold_reg  [2];
    logic [DATA_W-1:0]  hold_data [2];
    logic [1:0]         ready;

    // arbitration
    logic               grant;
    logic               sel;
    logic               prio;

    // write-port stage
    logic               regwrite_q, regwrite_d;
    logic [REG_AW-1:0]  wreg_q, wreg_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               gid_q, gid_d;

`ifdef ARB_FIXED_PRIO_EN
    assign prio = 1'b0;
`else
    logic prio_q, prio_d;

    // pointer moves past whoever was just served so the other wins next tie
    always_comb begin
        prio_d = prio_q;
        if (grant) begin
            prio_d = ~sel;
        end
    end

    // round-robin pointer register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    assign prio = prio_q;
`endif

    // selection depends on holding state only, never on incoming requests
    always_comb begin
        grant = full_v[0] | full_v[1];
        sel   = 1'b0;
        if (full_v == 2'b11) begin
            sel = prio;
        end else begin
            sel = full_v[1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_hold
            logic               full_q, full_d;
            logic [REG_AW-1:0]  reg_q, reg_d;
            logic [DATA_W-1:0]  data_q, data_d;
            logic               drain;
            logic               load;

            // an entry being drained this edge can be refilled on the same edge
            assign drain     = grant & (sel == 1'(gi));
            assign ready[gi] = ~full_q | drain;
            assign load      = req[gi] & ready[gi];

            // refill takes precedence over drain so sustained traffic never bubbles
            always_comb begin
                full_d = full_q;
                reg_d  = reg_q;
                data_d = data_q;
                if (drain) begin
                    full_d = 1'b0;
                end
                if (load) begin
                    full_d = 1'b1;
                    reg_d  = req_reg[gi];
                    data_d = req_data[gi];
                end
            end

            // holding register; reset drops any held write
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    full_q <= 1'b0;
                    reg_q  <= '0;
                    data_q <= '0;
                end else begin
                    full_q <= full_d;
                    reg_q  <= reg_d;
                    data_q <= data_d;
                end
            end

            assign full_v[gi]    = full_q;
            assign hold_reg[gi]  = reg_q;
            assign hold_data[gi] = data_q;
        end
    endgenerate

    // write stage loads the selected entry; address/data/id hold when idle
    always_comb begin
        regwrite_d = grant;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        gid_d      = gid_q;
        if (grant) begin
            wreg_d  = hold_reg[sel];
            wdata_d = hold_data[sel];
            gid_d   = sel;
        end
    end

    // registered write port; reset cancels an in-flight write
    always_ff @(posedge Clock) begin
        if (Reset) begin
            regwrite_q <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            gid_q      <= 1'b0;
        end else begin
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            gid_q      <= gid_d;
        end
    end

    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            assign bus.Busy[gi] = (full_v[0] & (hold_reg[0] == REG_AW'(gi)))
                                | (full_v[1] & (hold_reg[1] == REG_AW'(gi)))
                                | (regwrite_q & (wreg_q == REG_AW'(gi)));
        end
    endgenerate

    assign bus.Ready0     = ready[0];
    assign bus.Ready1     = ready[1];
    assign bus.RegWrite   = regwrite_q;
    assign bus.WriteRegNo = wreg_q;
    assign bus.WriteData  = wdata_q;
    assign bus.GrantId    = gid_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios with literal expectations
// plus randomized two-requester traffic against a behavioural model.
// Build with ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_regfile_wr_arbiter;
    localparam int DATA_W = 32;
    localparam int REG_AW = 2;
    localparam int NREG   = 4;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    regfile_wr_arbiter_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    regfile_wr_arbiter #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic chk_en = 1'b0;

    typedef struct {
        int          cyc;
        logic        gid;
        logic [1:0]  rn;
        logic [31:0] data;
    } wr_t;
    wr_t wlog[$];

    // stimulus streams: item = {reg, data}
    logic [33:0] q0[$];
    logic [33:0] q1[$];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // one pending slot per requester, the last requester served, and the
    // write the register file sees this cycle
    logic [1:0]  m_full;
    logic [1:0]  m_reg  [2];
    logic [31:0] m_data [2];
    logic        m_last;
    logic        m_we;
    logic [1:0]  m_wreg;
    logic [31:0] m_wdata;
    logic        m_gid;
    logic [1:0]  m_fire;

    logic        e_any;
    logic        e_pick;
    logic [1:0]  e_rdy;
    logic [3:0]  e_busy;

    // who is served at the next edge, who may transfer, what is pending
    always_comb begin
        e_any = m_full[0] | m_full[1];
        if (m_full[0] && m_full[1]) begin
`ifdef ARB_FIXED_PRIO_EN
            e_pick = 1'b0;
`else
            e_pick = ~m_last;
`endif
        end else begin
            e_pick = m_full[1];
        end
        e_rdy[0] = !m_full[0] || (e_any && e_pick == 1'b0);
        e_rdy[1] = !m_full[1] || (e_any && e_pick == 1'b1);
        e_busy = 4'b0000;
        for (int r = 0; r < NREG; r++) begin
            if ((m_full[0] && m_reg[0] == 2'(r)) || (m_full[1] && m_reg[1] == 2'(r)) ||
                (m_we && m_wreg == 2'(r)))
                e_busy[r] = 1'b1;
        end
    end

    // advance the model one clock
    always @(posedge Clock) begin
        cyc <= cyc + 1;
        if (Reset) begin
            m_full  <= 2'b00;
            m_reg[0] <= 2'd0;  m_reg[1] <= 2'd0;
            m_data[0] <= '0;   m_data[1] <= '0;
            m_last  <= 1'b1;
            m_we    <= 1'b0;
            m_wreg  <= 2'd0;
            m_wdata <= '0;
            m_gid   <= 1'b0;
            m_fire  <= 2'b00;
        end else begin
            m_fire[0] <= bus.Req0 & e_rdy[0];
            m_fire[1] <= bus.Req1 & e_rdy[1];
            m_we <= e_any;
            if (e_any) begin
                m_wreg  <= m_reg[e_pick];
                m_wdata <= m_data[e_pick];
                m_gid   <= e_pick;
                m_last  <= e_pick;
            end
            m_full[0] <= (bus.Req0 & e_rdy[0]) | (m_full[0] & !(e_any && e_pick == 1'b0));
            m_full[1] <= (bus.Req1 & e_rdy[1]) | (m_full[1] & !(e_any && e_pick == 1'b1));
            if (bus.Req0 & e_rdy[0]) begin
                m_reg[0]  <= bus.WrRegNo0;
                m_data[0] <= bus.WrData0;
            end
            if (bus.Req1 & e_rdy[1]) begin
                m_reg[1]  <= bus.WrRegNo1;
                m_data[1] <= bus.WrData1;
            end
        end
    end

    // every-cycle compare against the model, away from the active edge
    always @(negedge Clock) begin
        if (chk_en) begin
            cmp("RegWrite",   64'(bus.RegWrite),   64'(m_we));
            cmp("WriteRegNo", 64'(bus.WriteRegNo), 64'(m_wreg));
            cmp("WriteData",  64'(bus.WriteData),  64'(m_wdata));
            cmp("GrantId",    64'(bus.GrantId),    64'(m_gid));
            cmp("Busy",       64'(bus.Busy),       64'(e_busy));
            cmp("Ready0",     64'(bus.Ready0),     64'(e_rdy[0]));
            cmp("Ready1",     64'(bus.Ready1),     64'(e_rdy[1]));
            if (bus.RegWrite === 1'b1) begin
                wlog.push_back('{cyc, bus.GrantId, bus.WriteRegNo, bus.WriteData});
                $display("wr cyc=%0d gid=%0d reg=%0d data=%h",
                         cyc, bus.GrantId, bus.WriteRegNo, bus.WriteData);
            end
        end
    end

    task automatic step();
        @(negedge Clock);
        #1;
    endtask

    // play q0/q1 through the handshake; payload held until accepted
    task automatic run_streams(input int gap, input int max_cyc, output int n);
        logic a0, a1;
        a0 = 1'b0;
        a1 = 1'b0;
        n  = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < max_cyc) begin
            if (!a0 && q0.size() != 0 && $urandom_range(99) >= gap) begin
                a0 = 1'b1;
                bus.WrRegNo0 = q0[0][33:32];
                bus.WrData0  = q0[0][31:0];
            end
            if (!a1 && q1.size() != 0 && $urandom_range(99) >= gap) begin
                a1 = 1'b1;
                bus.WrRegNo1 = q1[0][33:32];
                bus.WrData1  = q1[0][31:0];
            end
            bus.Req0 = a0;
            bus.Req1 = a1;
            step();
            n++;
            if (a0 && m_fire[0]) begin
                void'(q0.pop_front());
                a0 = 1'b0;
            end
            if (a1 && m_fire[1]) begin
                void'(q1.pop_front());
                a1 = 1'b0;
            end
        end
        bus.Req0 = 1'b0;
        bus.Req1 = 1'b0;
        cmp("stream_drained", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    task automatic chk_consecutive(input string name);
        for (int j = 1; j < wlog.size(); j++)
            cmp(name, 64'(wlog[j].cyc - wlog[j-1].cyc), 64'd1);
    endtask

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [33:0] exp0[$];
        logic [33:0] exp1[$];
        logic [33:0] it;

        Reset = 1'b1;
        bus.Req0 = 1'b0; bus.WrRegNo0 = '0; bus.WrData0 = '0;
        bus.Req1 = 1'b0; bus.WrRegNo1 = '0; bus.WrData1 = '0;
        step();
        chk_en = 1'b1;
        step();
        Reset = 1'b0;

        // reset state
        cmp("rst_RegWrite", 64'(bus.RegWrite), 64'd0);
        cmp("rst_Busy",     64'(bus.Busy),     64'd0);
        cmp("rst_Ready0",   64'(bus.Ready0),   64'd1);
        cmp("rst_Ready1",   64'(bus.Ready1),   64'd1);
        cmp("rst_WriteData",64'(bus.WriteData),64'd0);

        // single write: accepted at edge N, on the port after edge N+1 only
        wlog.delete();
        bus.Req0 = 1'b1; bus.WrRegNo0 = 2'd1; bus.WrData0 = 32'hF8F8F8F8;
        step();
        bus.Req0 = 1'b0;
        cmp("sw_we_early", 64'(bus.RegWrite), 64'd0);
        cmp("sw_busy_held", 64'(bus.Busy), 64'b0010);
        step();
        cmp("sw_we",   64'(bus.RegWrite),   64'd1);
        cmp("sw_reg",  64'(bus.WriteRegNo), 64'd1);
        cmp("sw_data", 64'(bus.WriteData),  64'hF8F8F8F8);
        cmp("sw_gid",  64'(bus.GrantId),    64'd0);
        cmp("sw_busy_port", 64'(bus.Busy),  64'b0010);
        step();
        cmp("sw_we_drop",  64'(bus.RegWrite), 64'd0);
        cmp("sw_busy_clr", 64'(bus.Busy),     64'd0);
        cmp("sw_hold_data",64'(bus.WriteData),64'hF8F8F8F8);
        cmp("sw_count",    64'(wlog.size()),  64'd1);

        // reset mid-stream: entry 0 holds reg 2 / F0F0F0F0 while a write is on the port
        bus.Req0 = 1'b1; bus.WrRegNo0 = 2'd1; bus.WrData0 = 32'h11111111;
        step();
        bus.WrRegNo0 = 2'd2; bus.WrData0 = 32'hF0F0F0F0;
        step();
        bus.Req0 = 1'b0;
        cmp("mid_we",   64'(bus.RegWrite), 64'd1);
        cmp("mid_busy", 64'(bus.Busy),     64'b0110);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        cmp("mid_we_clr",  64'(bus.RegWrite), 64'd0);
        cmp("mid_busy_clr",64'(bus.Busy),     64'd0);
        cmp("mid_ready0",  64'(bus.Ready0),   64'd1);
        cmp("mid_ready1",  64'(bus.Ready1),   64'd1);
        wlog.delete();
        repeat (4) step();
        cmp("mid_no_replay", 64'(wlog.size()), 64'd0);

        // same-register collision, tie resolved toward requester 0
        wlog.delete();
        bus.Req0 = 1'b1; bus.WrRegNo0 = 2'd2; bus.WrData0 = 32'hFAFAFAFA;
        bus.Req1 = 1'b1; bus.WrRegNo1 = 2'd2; bus.WrData1 = 32'h12345678;
        step();
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        cmp("col_busy_a", 64'(bus.Busy[2]), 64'd1);
        step();
        cmp("col_first_data", 64'(bus.WriteData), 64'hFAFAFAFA);
        cmp("col_first_reg",  64'(bus.WriteRegNo), 64'd2);
        cmp("col_first_gid",  64'(bus.GrantId),   64'd0);
        cmp("col_busy_b", 64'(bus.Busy[2]), 64'd1);
        step();
        cmp("col_second_data", 64'(bus.WriteData), 64'h12345678);
        cmp("col_second_gid",  64'(bus.GrantId),   64'd1);
        cmp("col_busy_c", 64'(bus.Busy[2]), 64'd1);
        step();
        cmp("col_done", 64'(bus.RegWrite), 64'd0);
        cmp("col_count", 64'(wlog.size()), 64'd2);

        // contention: both requesters saturated
        wlog.delete();
`ifdef ARB_FIXED_PRIO_EN
        for (int k = 0; k < 6; k++) q0.push_back({2'd0, 32'(k)});
        q1.push_back({2'd3, 32'hFFFF0000});
        run_streams(0, 50, n);
        repeat (4) step();
        cmp("fix_accept_cycles", 64'(n), 64'd6);
        cmp("fix_writes", 64'(wlog.size()), 64'd7);
        for (int j = 0; j < wlog.size(); j++) begin
            cmp("fix_gid",  64'(wlog[j].gid),  (j < 6) ? 64'd0 : 64'd1);
            cmp("fix_data", 64'(wlog[j].data), (j < 6) ? 64'(j) : 64'hFFFF0000);
        end
`else
        for (int k = 0; k < 4; k++) begin
            q0.push_back({2'd0, 32'h00000000 + 32'(k)});
            q1.push_back({2'd3, 32'hFFFF0000 + 32'(k)});
        end
        run_streams(0, 50, n);
        repeat (4) step();
        cmp("rr_accept_cycles", 64'(n), 64'd7);
        cmp("rr_writes", 64'(wlog.size()), 64'd8);
        for (int j = 0; j < wlog.size(); j++) begin
            cmp("rr_gid",  64'(wlog[j].gid), 64'(j % 2));
            cmp("rr_reg",  64'(wlog[j].rn),  (j % 2 == 1) ? 64'd3 : 64'd0);
            cmp("rr_data", 64'(wlog[j].data),
                (j % 2 == 1) ? 64'(32'hFFFF0000 + 32'(j / 2)) : 64'(j / 2));
        end
`endif
        chk_consecutive("cont_back_to_back");

        // single requester streaming back to back
        wlog.delete();
        q1.push_back({2'd1, 32'hAAAA0001});
        q1.push_back({2'd1, 32'hBBBB0002});
        q1.push_back({2'd1, 32'hCCCC0003});
        q1.push_back({2'd1, 32'hDDDD0004});
        run_streams(0, 20, n);
        repeat (3) step();
        cmp("b2b_accept_cycles", 64'(n), 64'd4);
        cmp("b2b_writes", 64'(wlog.size()), 64'd4);
        if (wlog.size() == 4) begin
            cmp("b2b_data0", 64'(wlog[0].data), 64'hAAAA0001);
            cmp("b2b_data1", 64'(wlog[1].data), 64'hBBBB0002);
            cmp("b2b_data2", 64'(wlog[2].data), 64'hCCCC0003);
            cmp("b2b_data3", 64'(wlog[3].data), 64'hDDDD0004);
            cmp("b2b_gid",   64'(wlog[3].gid),  64'd1);
        end
        chk_consecutive("b2b_consecutive");

        // randomized traffic; also check per-requester write order end to end
        wlog.delete();
        for (int k = 0; k < 120; k++) begin
            it = {2'($urandom_range(3)), 32'($urandom)};
            q0.push_back(it);
            exp0.push_back(it);
            it = {2'($urandom_range(3)), 32'($urandom)};
            q1.push_back(it);
            exp1.push_back(it);
        end
        run_streams(35, 3000, n);
        repeat (4) step();
        cmp("rnd_writes", 64'(wlog.size()), 64'd240);
        for (int j = 0; j < wlog.size(); j++) begin
            if (wlog[j].gid == 1'b0 && exp0.size() != 0) begin
                it = exp0.pop_front();
                cmp("rnd_order0", {30'd0, wlog[j].rn, wlog[j].data}, 64'(it));
            end else if (wlog[j].gid == 1'b1 && exp1.size() != 0) begin
                it = exp1.pop_front();
                cmp("rnd_order1", {30'd0, wlog[j].rn, wlog[j].data}, 64'(it));
            end
        end
        cmp("rnd_left", 64'(exp0.size() + exp1.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
